fft_peak_picker: RTL

Streaming consumer placed directly downstream of the FFT core. It accepts the FFT's AXI-stream output frame of complex bins and computes each bin's squared magnitude in a short pipeline. Over a configurable bin window it tracks the strongest bin and reports that bin's index and magnitude once per frame to the note-detection logic.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/mag_sq.sv | 64 ++++++
 rtl/fft_peak_picker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT post-processing blocks.
package fft_pkg;

  localparam int unsigned NFFT  = 4096;
  localparam int unsigned BIN_W = 12;
  localparam int unsigned MAG_W = 17;

  typedef logic [BIN_W-1:0] bin_idx_t;
  typedef logic [MAG_W-1:0] mag_t;

  typedef struct packed {
    logic signed [7:0] re;
    logic signed [7:0] im;
  } cplx8_t;

  // FFT word layout: real part in the upper byte, imaginary in the lower byte.
  function automatic cplx8_t unpack_cplx(input logic [15:0] word);
    cplx8_t z;
    z.re = word[15:8];
    z.im = word[7:0];
    return z;
  endfunction

endpackage

// File: rtl/mag_sq.sv
// Two-stage squared-magnitude front end: register the complex sample, then
// register re^2 and im^2. Index/last/error sideband travels alongside.
module mag_sq
  import fft_pkg::*;
#(
  parameter int unsigned IDX_W = BIN_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  input  logic             in_err,
  output logic             out_valid,
  output logic [15:0]      out_re_sq,
  output logic [15:0]      out_im_sq,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_err
);

  cplx8_t             z_q;
  logic               s1_valid_q, s1_last_q, s1_err_q;
  logic [IDX_W-1:0]   s1_idx_q;
  logic signed [15:0] re_ext, im_ext, re_sq, im_sq;

  // Squares of 8-bit signed values fit in 16 bits and are never negative.
  always_comb begin
    re_ext = {{8{z_q.re[7]}}, z_q.re};
    im_ext = {{8{z_q.im[7]}}, z_q.im};
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_idx_q   <= '0;
      z_q        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_err    <= 1'b0;
      out_idx    <= '0;
      out_re_sq  <= '0;
      out_im_sq  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_last;
      s1_err_q   <= in_err;
      s1_idx_q   <= in_idx;
      z_q        <= unpack_cplx(in_data);
      out_valid  <= s1_valid_q;
      out_last   <= s1_last_q;
      out_err    <= s1_err_q;
      out_idx    <= s1_idx_q;
      out_re_sq  <= re_sq;
      out_im_sq  <= im_sq;
    end
  end

endmodule

// File: rtl/fft_peak_picker.sv
// Tracks the strongest bin of each FFT frame inside a bin window and reports
// its index and squared magnitude once per frame.
module fft_peak_picker
  import fft_pkg::*;
#(
  parameter int unsigned NFFT       = fft_pkg::NFFT,
  parameter int unsigned BIN_W      = fft_pkg::BIN_W,
  parameter int unsigned MIN_BIN    = 1,
  parameter int unsigned MAX_BIN    = 2047,
  parameter int unsigned MAG_THRESH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [15:0]      fft_data_in,
  input  logic             fft_valid_in,
  input  logic             fft_last_in,
  output logic             fft_ready_out,
  output logic [BIN_W-1:0] peak_bin_out,
  output logic [MAG_W-1:0] peak_mag_out,
  output logic             peak_valid_out,
  output logic             frame_error_out
);

  logic             beat, cnt_at_end;
  logic [BIN_W-1:0] cnt_q;

  logic             s2_valid, s2_last, s2_err;
  logic [BIN_W-1:0] s2_idx;
  logic [15:0]      s2_re_sq, s2_im_sq;

  logic             s3_valid_q, s3_last_q, s3_err_q;
  logic [BIN_W-1:0] s3_idx_q;
  logic [MAG_W-1:0] s3_mag_q;

  logic             fresh_q;
  logic [MAG_W-1:0] max_mag_q, base_mag, cand_mag;
  logic [BIN_W-1:0] max_bin_q, base_bin, cand_bin;
  logic             in_win;

  assign fft_ready_out = ~rst_in;
  assign beat          = fft_valid_in & fft_ready_out;
  assign cnt_at_end    = (cnt_q == BIN_W'(NFFT - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (beat) begin
      cnt_q <= (fft_last_in || cnt_at_end) ? '0 : cnt_q + 1'b1;
    end
  end

  // A frame ends on tlast or on the final counter value; a mismatch between
  // the two is a length error.
  mag_sq #(
    .IDX_W(BIN_W)
  ) u_mag_sq (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (beat),
    .in_data   (fft_data_in),
    .in_idx    (cnt_q),
    .in_last   (fft_last_in | cnt_at_end),
    .in_err    (fft_last_in ^ cnt_at_end),
    .out_valid (s2_valid),
    .out_re_sq (s2_re_sq),
    .out_im_sq (s2_im_sq),
    .out_idx   (s2_idx),
    .out_last  (s2_last),
    .out_err   (s2_err)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_err_q   <= 1'b0;
      s3_idx_q   <= '0;
      s3_mag_q   <= '0;
    end else begin
      s3_valid_q <= s2_valid;
      s3_last_q  <= s2_last;
      s3_err_q   <= s2_err;
      s3_idx_q   <= s2_idx;
      s3_mag_q   <= MAG_W'(s2_re_sq) + MAG_W'(s2_im_sq);
    end
  end

  // fresh_q marks the first entry of a frame, which compares against zero so
  // back-to-back frames never share a running max.
  always_comb begin
    base_mag = fresh_q ? '0 : max_mag_q;
    base_bin = fresh_q ? '0 : max_bin_q;
    in_win   = (32'(s3_idx_q) >= MIN_BIN) && (32'(s3_idx_q) <= MAX_BIN);
    cand_mag = base_mag;
    cand_bin = base_bin;
    if (in_win && (s3_mag_q > base_mag)) begin
      cand_mag = s3_mag_q;
      cand_bin = s3_idx_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fresh_q         <= 1'b1;
      max_mag_q       <= '0;
      max_bin_q       <= '0;
      peak_bin_out    <= '0;
      peak_mag_out    <= '0;
      peak_valid_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      peak_valid_out  <= 1'b0;
      frame_error_out <= 1'b0;
      if (s3_valid_q) begin
        if (s3_last_q) begin
          peak_valid_out  <= 1'b1;
          frame_error_out <= s3_err_q;
          peak_mag_out    <= cand_mag;
          peak_bin_out    <= (cand_mag < MAG_W'(MAG_THRESH)) ? '0 : cand_bin;
          fresh_q         <= 1'b1;
        end else begin
          max_mag_q <= cand_mag;
          max_bin_q <= cand_bin;
          fresh_q   <= 1'b0;
        end
      end
    end
  end

endmodule
